ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. It is the opposite direction of the existing keyboard receiver, which only listens on PS2_CLK/PS2_DAT.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) using the host-request sequence: clock inhibit, start bit, 8 data bits, odd parity, stop, then device ACK.
- Drives the inout lines open-drain through output-enables. The top level ties each pad to 1'bz, or to 0 when its enable is set.
- Asserts busy so the top level can ignore receiver output while a transfer is in progress.

---
 rtl/ps2_host_tx.sv | 187 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame on device clock, ACK check.
// Optional PS2_TX_GLITCH_FILTER_EN adds an 8-sample stability filter ahead of edge detection.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);
    localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, XFER, ACK, WAIT_REL} state_t;

    state_t         state, state_d;
    logic [9:0]     shift, shift_d;
    logic [3:0]     n, n_d;
    logic [TW-1:0]  tmr, tmr_d;
    logic           dat_oe_d, done_d, err_d;
    logic [1:0]     code_d;
    logic           accept;

    logic [1:0] clk_sync, dat_sync;
    logic       clk_f, dat_f, clk_prev, fe;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    // Filtered level follows the synchronised line only after 8 consecutive differing samples.
    logic [2:0] clk_run, dat_run;
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_f   <= 1'b1;
            dat_f   <= 1'b1;
            clk_run <= '0;
            dat_run <= '0;
        end else begin
            if (clk_sync[1] == clk_f) clk_run <= '0;
            else if (clk_run == 3'd7) begin
                clk_f   <= clk_sync[1];
                clk_run <= '0;
            end else clk_run <= clk_run + 3'd1;
            if (dat_sync[1] == dat_f) dat_run <= '0;
            else if (dat_run == 3'd7) begin
                dat_f   <= dat_sync[1];
                dat_run <= '0;
            end else dat_run <= dat_run + 3'd1;
        end
    end
`else
    assign clk_f = clk_sync[1];
    assign dat_f = dat_sync[1];
`endif

    always_ff @(posedge clk) begin
        if (reset) clk_prev <= 1'b1;
        else       clk_prev <= clk_f;
    end
    assign fe = clk_prev & ~clk_f;

    assign accept     = tx_valid && tx_ready && (state == IDLE);
    assign ps2_clk_oe = (state == INHIBIT) || (state == REQ);

    always_comb begin
        state_d  = state;
        shift_d  = shift;
        n_d      = n;
        tmr_d    = tmr;
        dat_oe_d = ps2_dat_oe;
        done_d   = 1'b0;
        err_d    = 1'b0;
        code_d   = err_code;
        case (state)
            IDLE: begin
                dat_oe_d = 1'b0;
                if (accept) begin
                    shift_d = {1'b1, ~^tx_data, tx_data};
                    n_d     = '0;
                    tmr_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (tmr == TW'(INHIBIT_CYCLES - 1)) begin
                    state_d  = REQ;
                    dat_oe_d = 1'b1;
                    tmr_d    = '0;
                end else tmr_d = tmr + TW'(1);
            end
            REQ: begin
                state_d = XFER;
                tmr_d   = '0;
            end
            XFER: begin
                if (fe) begin
                    dat_oe_d = ~shift[n];
                    n_d      = n + 4'd1;
                    tmr_d    = '0;
                    if (n == 4'd9) state_d = ACK;
                end else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
                    dat_oe_d = 1'b0;
                    err_d    = 1'b1;
                    code_d   = 2'b01;
                    state_d  = IDLE;
                end else tmr_d = tmr + TW'(1);
            end
            ACK: begin
                if (fe) begin
                    tmr_d = '0;
                    if (!dat_f) state_d = WAIT_REL;
                    else begin
                        err_d   = 1'b1;
                        code_d  = 2'b10;
                        state_d = IDLE;
                    end
                end else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
                    dat_oe_d = 1'b0;
                    err_d    = 1'b1;
                    code_d   = 2'b01;
                    state_d  = IDLE;
                end else tmr_d = tmr + TW'(1);
            end
            WAIT_REL: begin
                if (clk_f && dat_f) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (fe) tmr_d = '0;
                else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
                    dat_oe_d = 1'b0;
                    err_d    = 1'b1;
                    code_d   = 2'b01;
                    state_d  = IDLE;
                end else tmr_d = tmr + TW'(1);
            end
            default: begin
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shift      <= '0;
            n          <= '0;
            tmr        <= '0;
            ps2_dat_oe <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
            busy       <= 1'b0;
            tx_ready   <= 1'b0;
        end else begin
            state      <= state_d;
            shift      <= shift_d;
            n          <= n_d;
            tmr        <= tmr_d;
            ps2_dat_oe <= dat_oe_d;
            done       <= done_d;
            err        <= err_d;
            err_code   <= code_d;
            busy       <= (state_d != IDLE);
            // Ready lags the return to IDLE by one cycle and drops immediately on acceptance.
            tx_ready   <= (state == IDLE) && !accept;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model on wired-AND pads, scoreboard of expected outcomes.
module tb_ps2_host_tx;
    localparam int INH = 50;
    localparam int TO  = 2000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic       busy, done, err;
    logic [1:0] err_code;
    logic       dev_clk = 1'b1, dev_dat = 1'b1;

    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in), .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe), .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic       is_err;
        logic [1:0] code;
        logic [7:0] data;
        logic       par;
    } exp_t;
    exp_t exp_q[$];

    // Device model: 0 normal, 1 never clocks, 2 NACK, 3 normal with a short clock glitch
    int         dev_mode = 0;
    logic       dev_busy = 1'b0;
    int         dev_bitn = 0;
    logic [7:0] dev_byte = 8'h00;
    logic       dev_par = 1'b0, dev_start = 1'b1, dev_stop = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!reset && ps2_clk_in && !ps2_dat_in) begin
            dev_busy = 1'b1;
            dev_bitn = 0;
            if (dev_mode == 1) begin
                for (int k = 0; k < 5000 && !ps2_dat_in; k++) @(negedge clk);
            end else begin
                repeat (20) @(negedge clk);
                dev_start = ps2_dat_in;
                for (int i = 0; i < 10; i++) begin
                    dev_clk = 1'b0;
                    repeat (40) @(negedge clk);
                    dev_clk = 1'b1;
                    @(negedge clk);
                    if (i < 8) dev_byte[i] = ps2_dat_in;
                    else if (i == 8) dev_par = ps2_dat_in;
                    else dev_stop = ps2_dat_in;
                    dev_bitn = i + 1;
                    if (i == 9) dev_dat = (dev_mode == 2);
                    if (dev_mode == 3 && i == 2) begin
                        repeat (10) @(negedge clk);
                        dev_clk = 1'b0;
                        repeat (3) @(negedge clk);
                        dev_clk = 1'b1;
                        repeat (26) @(negedge clk);
                    end else repeat (39) @(negedge clk);
                end
                dev_clk = 1'b0;
                repeat (40) @(negedge clk);
                dev_clk = 1'b1;
                dev_dat = 1'b1;
            end
            dev_busy = 1'b0;
        end
    end

    // Monitor: every done/err pulse is matched against the oldest expectation
    logic done_prev = 1'b0;
    logic chk_rdy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (chk_rdy) begin
            check("tx_ready_after_return", tx_ready, 1);
            chk_rdy = 1'b0;
        end
        if (!reset && (done || err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: done=%0b err=%0b code=%0b, none expected", done, err, err_code);
            end else begin
                e = exp_q.pop_front();
                check("outcome_is_err", err, e.is_err);
                check("outcome_done", done, !e.is_err);
                check("busy_at_pulse", busy, 0);
                if (e.is_err) begin
                    check("err_code", err_code, e.code);
                    check("oe_released_at_err", {ps2_clk_oe, ps2_dat_oe}, 0);
                end else begin
                    check("frame_data", dev_byte, e.data);
                    check("frame_parity", dev_par, e.par);
                    check("frame_start", dev_start, 0);
                    check("frame_stop", dev_stop, 1);
                    check("done_one_cycle", done_prev, 0);
                    chk_rdy = 1'b1;
                end
            end
        end
        done_prev = done;
    end

    task automatic send(input logic [7:0] d);
        int k;
        for (k = 0; k < 5000 && !tx_ready; k++) @(negedge clk);
        if (!tx_ready) check("send_wait_ready", 0, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic expect_done(input logic [7:0] d, input logic p);
        exp_t e;
        e.is_err = 1'b0; e.code = 2'b00; e.data = d; e.par = p;
        exp_q.push_back(e);
    endtask

    task automatic expect_err(input logic [1:0] c);
        exp_t e;
        e.is_err = 1'b1; e.code = c; e.data = 8'h00; e.par = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string nm);
        int k;
        for (k = 0; k < 20000 && (busy || dev_busy || !tx_ready); k++) @(negedge clk);
        if (busy || dev_busy || !tx_ready) check({nm, "_idle_timeout"}, 0, 1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int cnt, t0, t1, k;
        repeat (3) @(negedge clk);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_dat_oe", ps2_dat_oe, 0);
        check("rst_busy_done_err", {busy, done, err}, 0);
        check("rst_err_code", err_code, 0);
        check("rst_tx_ready", tx_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("tx_ready_after_reset", tx_ready, 1);

        // 0xED: inhibit length, frame content, ACK
        expect_done(8'hED, 1'b1);
        send(8'hED);
        check("busy_after_accept", busy, 1);
        cnt = 0;
        for (k = 0; k < 300; k++) begin
            if (ps2_dat_oe) break;
            if (ps2_clk_oe) cnt++;
            @(negedge clk);
        end
        check("inhibit_cycles", cnt, INH);
        wait_idle("ed");

        expect_done(8'h00, 1'b1);
        send(8'h00);
        wait_idle("x00");
        expect_done(8'h01, 1'b0);
        send(8'h01);
        wait_idle("x01");

        // Device silent: timeout exactly TO cycles after XFER entry
        dev_mode = 1;
        expect_err(2'b01);
        send(8'h12);
        for (k = 0; k < 500 && !(!ps2_clk_oe && ps2_dat_oe); k++) @(negedge clk);
        t0 = cyc;
        for (k = 0; k < 3000 && !err; k++) @(negedge clk);
        t1 = cyc;
        check("timeout_latency", t1 - t0, TO);
        wait_idle("timeout");

        // NACK
        dev_mode = 2;
        expect_err(2'b10);
        send(8'h5A);
        wait_idle("nack");

        // Reset during bit 4, then a clean 0xFF
        dev_mode = 0;
        send(8'h55);
        for (k = 0; k < 2000 && dev_bitn != 4; k++) @(negedge clk);
        check("reached_bit4", dev_bitn, 4);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
        check("midrst_done_err", {done, err}, 0);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_tx_ready", tx_ready, 1);
        wait_idle("midrst");
        expect_done(8'hFF, 1'b1);
        send(8'hFF);
        wait_idle("xff");

        // tx_valid while busy is ignored
        expect_done(8'h3C, 1'b1);
        send(8'h3C);
        repeat (100) @(negedge clk);
        check("ready_low_while_busy", tx_ready, 0);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle("busy_req");

`ifdef PS2_TX_GLITCH_FILTER_EN
        dev_mode = 3;
        expect_done(8'hA5, 1'b1);
        send(8'hA5);
        wait_idle("glitch");
        dev_mode = 0;
`endif

        repeat (50) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
